multicycle_control: RTL
=======================

# multicycle_control

Multicycle sequencing controller for the MIPS core. It replaces the single-cycle decoder with a Moore/Mealy FSM, so one unified memory, one ALU and one adder-free PC path can be shared across the cycles of each instruction. It sits between the instruction register opcode field and the datapath mux selects and strobes. It also absorbs variable-latency memory through a `mem_ready` handshake with a bounded wait timeout. PC is word-addressed, so the increment is +1.

## Interface
- `MAX_WAIT`, default 15: maximum consecutive cycles a memory state waits with `mem_ready` low before aborting (range 2..255).
- `clk`  in  1  system clock, rising edge.
- `res`  in  1  synchronous, active-high reset.
- `opcode`  in  6  instruction register bits [31:26].
- `mem_ready`  in  1  memory completes the current access this cycle.
- `pc_write`, `pc_write_cond`, `ir_write`, `reg_write`, `mem_read`, `mem_write`  out  1 each  datapath strobes.
- `i_or_d`  out  1  memory address select: 0 = PC, 1 = ALUOut.
- `mem_to_reg`, `reg_dst`, `alu_src_a`  out  1 each  mux selects.
- `alu_src_b`  out  2  ALU B select: 00 = B reg, 01 = const 1, 10 = sign-ext imm, 11 = sign-ext offset.
- `alu_op`  out  2  to ALU_Control: 00 = add, 01 = sub, 10 = funct.
- `pc_source`  out  2  PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state`  out  4  current state encoding, for debug.
- `illegal_op`  out  1  registered one-cycle pulse on an undecodable opcode.
- `mem_timeout`  out  1  registered one-cycle pulse on a wait abort.

## Operation
- Unlisted outputs are 0 in each state.
- FETCH (0): `mem_read`=1, `i_or_d`=0, `alu_src_b`=01, `alu_op`=00.
  - `ir_write` and `pc_write` follow `mem_ready` (Mealy).
  - Goes to DECODE on `mem_ready`.
- DECODE (1): `alu_src_b`=11, `alu_op`=00; precomputes PC+1+offset into ALUOut.
  - Dispatch on opcode: 100011 (lw) or 101011 (sw) → MEM_ADDR; 000000 → R_EXEC; 000100 → BRANCH; 000010 → JUMP (macro-dependent).
  - Any other opcode → FETCH, and `illegal_op` pulses the next cycle.
- MEM_ADDR (2): `alu_src_a`=1, `alu_src_b`=10. Goes to MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ (3): `mem_read`=1, `i_or_d`=1. Goes to MEM_WB on `mem_ready`.
- MEM_WB (4): `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. Goes to FETCH.
- MEM_WRITE (5): `mem_write`=1, `i_or_d`=1, held through the wait. Goes to FETCH on `mem_ready`.
- R_EXEC (6): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. Goes to R_WB.
- R_WB (7): `reg_write`=1, `reg_dst`=1. Goes to FETCH.
- BRANCH (8): `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_write_cond`=1, `pc_source`=01. Goes to FETCH.
- JUMP (9): `pc_write`=1, `pc_source`=10. Goes to FETCH.
- Unused encodings 10–15 → FETCH next cycle.
- Wait counter (8 bit):
  - Counts cycles spent in FETCH, MEM_READ or MEM_WRITE with `mem_ready`=0.
  - Clears on any state change or on `mem_ready`=1.
  - When the count reaches `MAX_WAIT`−1 and `mem_ready` is still 0, the FSM goes to FETCH and `mem_timeout` pulses. A FETCH timeout re-enters FETCH with PC unchanged, because `pc_write` was never asserted.
- `mem_ready` high in the same cycle as the abort threshold: ready wins and the normal transition is taken.

## Timing
- Reset: on the first edge with `res`=1, the state goes to FETCH and the counter, `illegal_op` and `mem_timeout` go to 0.
- While `res` is high, every strobe and select output is forced to 0. `state` reads 0.
- Reset mid-instruction aborts it. Strobes drop in the same cycle `res` is seen, combinationally.
- Latency with `mem_ready` tied high:
  - R-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - j: 3 cycles.
- Each wait cycle adds 1.
- Strobes are valid for the entire state cycle. Memory sampling of `mem_read`/`mem_write` is the memory's concern.

## Configuration
- `MC_JUMP_EN` defined: opcode 000010 dispatches to JUMP and `pc_source`=10 is reachable.
- `MC_JUMP_EN` undefined: JUMP is not implemented, and opcode 000010 is treated as illegal (→ FETCH, `illegal_op` pulse). `pc_source` never exceeds 01.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state encodings S_FETCH..S_JUMP;
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J;
  - ALU_B_* and PCSRC_* select codes;
  - ALUOP_* codes.
- Sub-module `mem_wait_timer`: parameterised by `MAX_WAIT`. Inputs are `clk`, `res`, `waiting`, `clear`; output is a one-cycle `expired` flag.
- The FSM top holds the state register, next-state logic and output decode.

## Test plan
- Reset, then `mem_ready`=1, opcode 000000: states 0,1,6,7,0. `reg_write`=1 with `reg_dst`=1 only in cycle 4; `pc_write`=1 only in cycle 1.
- opcode 100011 with `mem_ready` low for 3 cycles in MEM_READ: states 0,1,2,3,3,3,3,4,0. `mem_read` and `i_or_d` stay 1 throughout the wait.
- opcode 101011 with `mem_ready` never asserted and `MAX_WAIT`=4:
  - 4 cycles in MEM_WRITE, then FETCH;
  - `mem_timeout` pulses once;
  - no `reg_write` at any point.
- opcode 000010: with `MC_JUMP_EN`, states 0,1,9,0 with `pc_source`=10. Without it, states 0,1,0 with `illegal_op`=1 for one cycle.
- Assert `res` during MEM_WB: all strobes are 0 in that cycle. `state`=0 at the next edge, and fetch resumes after release.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, select codes.
// No logic here. No flow control.
// Pure constants and types.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_B_REG = 2'b00;
    localparam logic [1:0] ALU_B_ONE = 2'b01;
    localparam logic [1:0] ALU_B_IMM = 2'b10;
    localparam logic [1:0] ALU_B_OFF = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // States that stall on the memory handshake and are subject to the wait timeout.
    function automatic logic is_mem_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory-stall cycles; flags expiry on the (MAX_WAIT-1)th stalled count.
// expired is combinational from the registered count; count restarts on clear or expiry.
// No backpressure: the controller consumes expired in the same cycle.
module mem_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic clk,
    input  logic res,
    input  logic waiting,
    input  logic clear,
    output logic expired
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    assign expired = waiting && (count_q == 8'(MAX_WAIT - 1));

    always_comb begin
        count_d = count_q + 8'd1;
        if (clear || !waiting || expired) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS sequencing FSM driving datapath strobes/selects; MC_JUMP_EN enables the j instruction.
// Latency: R 4, lw 5, sw 4, beq 3, j 3 cycles plus one per memory stall cycle.
// Memory stalls via mem_ready with a MAX_WAIT abort back to FETCH; illegal_op/mem_timeout are registered pulses.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       res,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       i_or_d,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       mem_timeout
);

    state_t state_q, state_d;
    logic   illegal_op_q, illegal_op_d;
    logic   mem_timeout_q, mem_timeout_d;
    logic   waiting;
    logic   timer_expired;
    ctrl_t  ctrl;

    assign waiting = is_mem_wait_state(state_q) && !mem_ready;

    mem_wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk     (clk),
        .res     (res),
        .waiting (waiting),
        .clear   (state_d != state_q),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (res) begin
            state_q       <= S_FETCH;
            illegal_op_q  <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            illegal_op_q  <= illegal_op_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = S_R_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_JUMP_EN
                    OP_J:         state_d = S_JUMP;
`endif
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            S_MEM_READ: begin
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timer_expired) begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_WRITE: begin
                if (mem_ready || timer_expired) begin
                    state_d = S_FETCH;
                end
            end
            S_R_EXEC: state_d = S_R_WB;
            default:  state_d = S_FETCH;
        endcase
    end

    // DECODE only falls back to FETCH when the opcode has no dispatch target.
    always_comb begin
        illegal_op_d  = (state_q == S_DECODE) && (state_d == S_FETCH);
        mem_timeout_d = timer_expired;
    end

    always_comb begin
        ctrl = '0;
        if (!res) begin
            case (state_q)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = ALU_B_ONE;
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_b = ALU_B_OFF;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                S_MEM_ADDR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = ALU_B_IMM;
                end
                S_MEM_READ: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                S_MEM_WRITE: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.i_or_d    = 1'b1;
                end
                S_R_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = ALU_B_REG;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
                S_R_WB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = ALU_B_REG;
                    ctrl.alu_op        = ALUOP_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                end
`ifdef MC_JUMP_EN
                S_JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_JUMP;
                end
`endif
                default: ;
            endcase
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_write_cond = ctrl.pc_write_cond;
    assign ir_write      = ctrl.ir_write;
    assign reg_write     = ctrl.reg_write;
    assign mem_read      = ctrl.mem_read;
    assign mem_write     = ctrl.mem_write;
    assign i_or_d        = ctrl.i_or_d;
    assign mem_to_reg    = ctrl.mem_to_reg;
    assign reg_dst       = ctrl.reg_dst;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ctrl.alu_op;
    assign pc_source     = ctrl.pc_source;
    assign state         = res ? 4'd0 : 4'(state_q);
    assign illegal_op    = illegal_op_q;
    assign mem_timeout   = mem_timeout_q;

endmodule
